pdp11_mem_arbiter: RTL and testbench



---
 rtl/pdp11_mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_pdp11_mem_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdp11_mem_arbiter.sv
// pdp11_mem_arbiter: shares the PDP-11 data-memory port among NUM_REQ requesters.
// Build option PDP11_ARB_RR_EN selects round-robin arbitration (default: fixed priority).
//
// state | meaning
// IDLE  | arbitrate pending requests, latch winner and its fields
// BUSY  | memory strobe active, timeout counter running
// RESP  | one-cycle done/err pulse to the granted requester
module pdp11_mem_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_we,
  input  logic [NUM_REQ-1:0]      req_byte,
  input  logic [NUM_REQ*16-1:0]   req_addr,
  input  logic [NUM_REQ*16-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      rsp_done,
  output logic [NUM_REQ-1:0]      rsp_err,
  output logic                    rsp_trap_nxm,
  output logic [15:0]             rsp_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [1:0]              mem_be,
  output logic [15:0]             mem_addr,
  output logic [15:0]             mem_wdata,
  input  logic [15:0]             mem_rdata,
  input  logic                    mem_ready
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0] REQ_ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] g_idx;
  logic             g_we, g_byte, g_err, g_nxm;
  logic [15:0]      g_addr, g_wdata, g_rdata;
  logic [CNT_W-1:0] tmo_cnt;

  logic             grant_any;
  logic [IDX_W-1:0] grant_idx;
  int               cand;
  logic             sel_we, sel_byte, sel_odd;
  logic [15:0]      sel_addr, sel_wdata;
  logic             tmo_hit, busy, resp;
  logic [15:0]      rd_lane;

`ifdef PDP11_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= IDX_W'(NUM_REQ - 1);
    end else if (state == IDLE && grant_any) begin
      rr_ptr <= grant_idx;
    end
  end
`endif

  // First valid requester in search order wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef PDP11_ARB_RR_EN
      cand = (int'(rr_ptr) + 1 + i) % NUM_REQ;
`else
      cand = i;
`endif
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
  end

  assign sel_we    = req_we[grant_idx];
  assign sel_byte  = req_byte[grant_idx];
  assign sel_addr  = req_addr[16*grant_idx +: 16];
  assign sel_wdata = req_wdata[16*grant_idx +: 16];
  assign sel_odd   = !sel_byte && sel_addr[0];

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));
  assign rd_lane = !g_byte ? mem_rdata :
                   (g_addr[0] ? {8'h00, mem_rdata[15:8]} : {8'h00, mem_rdata[7:0]});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = sel_odd ? RESP : BUSY;
      BUSY:    if (mem_ready || tmo_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_idx   <= '0;
      g_we    <= 1'b0;
      g_byte  <= 1'b0;
      g_err   <= 1'b0;
      g_nxm   <= 1'b0;
      g_addr  <= '0;
      g_wdata <= '0;
      g_rdata <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (grant_any) begin
            g_idx   <= grant_idx;
            g_we    <= sel_we;
            g_byte  <= sel_byte;
            g_addr  <= sel_addr;
            g_wdata <= sel_wdata;
            g_err   <= sel_odd;
            g_nxm   <= 1'b0;
          end
        end
        BUSY: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // A ready on the final cycle beats the timeout.
          if (mem_ready) begin
            g_rdata <= rd_lane;
          end else if (tmo_hit) begin
            g_err <= 1'b1;
            g_nxm <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == BUSY);
  assign resp = (state == RESP);

  assign mem_req   = busy;
  assign mem_we    = busy && g_we;
  assign mem_be    = !busy ? 2'b00 : (!g_byte ? 2'b11 : (g_addr[0] ? 2'b10 : 2'b01));
  assign mem_addr  = busy ? {g_addr[15:1], 1'b0} : 16'h0000;
  assign mem_wdata = !busy ? 16'h0000 : (g_byte ? {2{g_wdata[7:0]}} : g_wdata);

  assign rsp_done     = (resp && !g_err) ? (REQ_ONE << g_idx) : '0;
  assign rsp_err      = (resp &&  g_err) ? (REQ_ONE << g_idx) : '0;
  assign rsp_trap_nxm = resp && g_err && g_nxm;
  assign rsp_rdata    = (resp && !g_err) ? g_rdata : 16'h0000;

endmodule

// File: tb/tb_pdp11_mem_arbiter.sv
// Bench for pdp11_mem_arbiter: reactive memory, directed bus-rule cases and random
// transactions checked against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_pdp11_mem_arbiter;
  localparam int NUM_REQ = 3;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid, req_we, req_byte;
  logic [47:0] req_addr, req_wdata;
  logic [2:0]  rsp_done, rsp_err;
  logic        rsp_trap_nxm;
  logic [15:0] rsp_rdata;
  logic        mem_req, mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;

  int vectors = 0;
  int miscompares = 0;
  int mem_lat = 1;
  int busy_cnt = 0;
  logic [15:0] mem_arr [256];
  logic [15:0] ref_mem [256];

  typedef struct {
    bit          pulsed;
    int          cyc;
    logic [2:0]  done;
    logic [2:0]  err;
    logic        nxm;
    logic [15:0] rdata;
    int          mreq_cyc;
    logic        we;
    logic [1:0]  be;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          unstable;
    bit          extra;
  } obs_t;

  always #5 clk = ~clk;

  pdp11_mem_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_done(rsp_done), .rsp_err(rsp_err), .rsp_trap_nxm(rsp_trap_nxm), .rsp_rdata(rsp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // Memory device: ready on the mem_lat-th strobe cycle (0 = never); junk on ready otherwise.
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      busy_cnt  = busy_cnt + 1;
      mem_ready = (mem_lat != 0) && (busy_cnt == mem_lat);
    end else begin
      busy_cnt  = 0;
      mem_ready = 1'($urandom_range(0, 1));
    end
    mem_rdata = (mem_ready && mem_req) ? mem_arr[mem_addr[8:1]] : 16'($urandom);
    if (mem_ready && mem_req && mem_we) begin
      if (mem_be[0]) mem_arr[mem_addr[8:1]][7:0]  = mem_wdata[7:0];
      if (mem_be[1]) mem_arr[mem_addr[8:1]][15:8] = mem_wdata[15:8];
    end
  end

  task automatic clr_obs(output obs_t o);
    o.pulsed = 0; o.cyc = 0; o.done = '0; o.err = '0; o.nxm = 1'b0; o.rdata = '0;
    o.mreq_cyc = 0; o.we = 1'b0; o.be = '0; o.addr = '0; o.wdata = '0;
    o.unstable = 0; o.extra = 0;
  endtask

  // Starts at a negedge with the arbiter idle; cycle 0 is the request cycle.
  task automatic run_txn(input int idx, input logic we, input logic byt, input logic [15:0] addr,
                         input logic [15:0] wdata, input int lat, output obs_t o);
    clr_obs(o);
    mem_lat = lat;
    req_we[idx] = we;
    req_byte[idx] = byt;
    req_addr[16*idx +: 16] = addr;
    req_wdata[16*idx +: 16] = wdata;
    req_valid[idx] = 1'b1;
    for (int c = 1; c <= TIMEOUT + 8; c++) begin
      @(negedge clk);
      if (mem_req) begin
        if (o.mreq_cyc == 0) begin
          o.we = mem_we; o.be = mem_be; o.addr = mem_addr; o.wdata = mem_wdata;
        end else if ({mem_we, mem_be, mem_addr, mem_wdata} != {o.we, o.be, o.addr, o.wdata}) begin
          o.unstable = 1;
        end
        o.mreq_cyc++;
      end
      if ((rsp_done | rsp_err) != 3'b000) begin
        o.pulsed = 1; o.cyc = c; o.done = rsp_done; o.err = rsp_err;
        o.nxm = rsp_trap_nxm; o.rdata = rsp_rdata;
        req_valid[idx] = 1'b0;
        break;
      end
    end
    if (o.pulsed) begin
      @(negedge clk);
      o.extra = ((rsp_done | rsp_err) != 3'b000) || mem_req;
    end else begin
      req_valid[idx] = 1'b0;
    end
  endtask

  // Transaction-level model of the bus rules; also updates the reference memory.
  task automatic model_txn(input int idx, input logic we, input logic byt, input logic [15:0] addr,
                           input logic [15:0] wdata, input int lat, output obs_t e);
    logic [15:0] word;
    logic [2:0]  oh;
    clr_obs(e);
    oh = 3'b001 << idx;
    word = ref_mem[addr[8:1]];
    e.pulsed = 1;
    e.we = we;
    e.addr = {addr[15:1], 1'b0};
    e.be = !byt ? 2'b11 : (addr[0] ? 2'b10 : 2'b01);
    e.wdata = byt ? {wdata[7:0], wdata[7:0]} : wdata;
    if (!byt && addr[0]) begin
      e.cyc = 1; e.err = oh; e.nxm = 1'b0; e.mreq_cyc = 0;
    end else if (lat >= 1 && lat <= TIMEOUT) begin
      e.cyc = lat + 1; e.done = oh; e.mreq_cyc = lat;
      e.rdata = !byt ? word : (addr[0] ? {8'h00, word[15:8]} : {8'h00, word[7:0]});
      if (we) begin
        if (e.be[0]) ref_mem[addr[8:1]][7:0]  = e.wdata[7:0];
        if (e.be[1]) ref_mem[addr[8:1]][15:8] = e.wdata[15:8];
      end
    end else begin
      e.cyc = TIMEOUT + 1; e.err = oh; e.nxm = 1'b1; e.mreq_cyc = TIMEOUT;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, rsp_done, rsp_err, rsp_trap_nxm, rsp_rdata} !== 58'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got req=%b we=%b be=%b addr=%h wd=%h done=%b err=%b nxm=%b rd=%h required all zero",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, rsp_done, rsp_err, rsp_trap_nxm, rsp_rdata);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({mem_req, rsp_done, rsp_err} !== 7'b0) begin
      miscompares++;
      $display("FAIL idle_quiet: got req=%b done=%b err=%b required 0", mem_req, rsp_done, rsp_err);
    end
  endtask

  task automatic test_word_read;
    obs_t o;
    mem_arr[0] = 16'h1234;
    ref_mem[0] = 16'h1234;
    run_txn(0, 1'b0, 1'b0, 16'o001000, 16'h0000, 2, o);
    vectors++;
    if (!o.pulsed || o.cyc != 3 || o.done !== 3'b001 || o.err !== 3'b000) begin
      miscompares++;
      $display("FAIL word_read_pulse: got cyc=%0d done=%b err=%b required cyc=3 done=001 err=000", o.cyc, o.done, o.err);
    end
    vectors++;
    if (o.rdata !== 16'h1234) begin
      miscompares++;
      $display("FAIL word_read_data: got %h required 1234", o.rdata);
    end
    vectors++;
    if (o.addr !== 16'o001000 || o.be !== 2'b11 || o.we !== 1'b0 || o.mreq_cyc != 2 || o.unstable || o.extra) begin
      miscompares++;
      $display("FAIL word_read_bus: got addr=%o be=%b we=%b mreq=%0d unst=%0d extra=%0d required addr=1000 be=11 we=0 mreq=2",
               o.addr, o.be, o.we, o.mreq_cyc, o.unstable, o.extra);
    end
  endtask

  task automatic test_byte_write;
    obs_t o;
    run_txn(2, 1'b1, 1'b1, 16'o001001, 16'h00A5, 1, o);
    ref_mem[0] = 16'hA534;
    vectors++;
    if (o.be !== 2'b10 || o.addr !== 16'o001000 || o.wdata !== 16'hA5A5 || o.we !== 1'b1) begin
      miscompares++;
      $display("FAIL byte_write_bus: got be=%b addr=%o wd=%h we=%b required be=10 addr=1000 wd=a5a5 we=1",
               o.be, o.addr, o.wdata, o.we);
    end
    vectors++;
    if (o.done !== 3'b100 || o.err !== 3'b000 || o.cyc != 2) begin
      miscompares++;
      $display("FAIL byte_write_pulse: got done=%b err=%b cyc=%0d required done=100 err=000 cyc=2", o.done, o.err, o.cyc);
    end
    run_txn(1, 1'b0, 1'b0, 16'o001000, 16'h0000, 1, o);
    vectors++;
    if (o.rdata !== 16'hA534 || o.done !== 3'b010) begin
      miscompares++;
      $display("FAIL byte_write_readback: got rd=%h done=%b required a534 010", o.rdata, o.done);
    end
    run_txn(0, 1'b0, 1'b1, 16'o001001, 16'h0000, 3, o);
    vectors++;
    if (o.rdata !== 16'h00A5 || o.be !== 2'b10 || o.cyc != 4) begin
      miscompares++;
      $display("FAIL byte_read_odd: got rd=%h be=%b cyc=%0d required 00a5 10 4", o.rdata, o.be, o.cyc);
    end
  endtask

  task automatic test_odd_trap;
    obs_t o;
    run_txn(0, 1'b0, 1'b0, 16'o000003, 16'h0000, 1, o);
    vectors++;
    if (o.cyc != 1 || o.err !== 3'b001 || o.done !== 3'b000 || o.nxm !== 1'b0) begin
      miscompares++;
      $display("FAIL odd_trap_pulse: got cyc=%0d err=%b done=%b nxm=%b required 1 001 000 0", o.cyc, o.err, o.done, o.nxm);
    end
    vectors++;
    if (o.mreq_cyc != 0 || o.extra) begin
      miscompares++;
      $display("FAIL odd_trap_mem: got mreq cycles=%0d extra=%0d required 0 0", o.mreq_cyc, o.extra);
    end
  endtask

  task automatic test_nxm_timeout;
    obs_t o;
    run_txn(1, 1'b0, 1'b0, 16'o000100, 16'h0000, 0, o);
    vectors++;
    if (o.mreq_cyc != TIMEOUT) begin
      miscompares++;
      $display("FAIL nxm_mreq_len: got %0d required %0d", o.mreq_cyc, TIMEOUT);
    end
    vectors++;
    if (!o.pulsed || o.cyc != TIMEOUT + 1 || o.err !== 3'b010 || o.nxm !== 1'b1 || o.done !== 3'b000 || o.extra) begin
      miscompares++;
      $display("FAIL nxm_pulse: got cyc=%0d err=%b nxm=%b done=%b extra=%0d required %0d 010 1 000 0",
               o.cyc, o.err, o.nxm, o.done, o.extra, TIMEOUT + 1);
    end
  endtask

  task automatic test_random;
    obs_t o, e;
    int idx, lat, r;
    logic we, byt;
    logic [15:0] addr, wdata;
    for (int t = 0; t < 40; t++) begin
      req_we = 3'($urandom); req_byte = 3'($urandom);
      req_addr = {$urandom, 16'($urandom)}; req_wdata = {$urandom, 16'($urandom)};
      idx = $urandom_range(0, NUM_REQ - 1);
      we = 1'($urandom); byt = 1'($urandom);
      addr = 16'($urandom); wdata = 16'($urandom);
      r = $urandom_range(0, 9);
      if (r <= 5) lat = r + 1;
      else if (r == 6) lat = TIMEOUT;
      else if (r == 7) lat = TIMEOUT + 1;
      else if (r == 8) lat = 0;
      else lat = $urandom_range(1, 10);
      model_txn(idx, we, byt, addr, wdata, lat, e);
      run_txn(idx, we, byt, addr, wdata, lat, o);
      vectors++;
      if (!o.pulsed || o.cyc != e.cyc) begin
        miscompares++;
        $display("FAIL rnd_cycle t=%0d: got pulsed=%0d cyc=%0d required cyc=%0d", t, o.pulsed, o.cyc, e.cyc);
      end
      vectors++;
      if ({o.done, o.err} !== {e.done, e.err}) begin
        miscompares++;
        $display("FAIL rnd_resp t=%0d: got done=%b err=%b required done=%b err=%b", t, o.done, o.err, e.done, e.err);
      end
      if (e.err != 3'b000) begin
        vectors++;
        if (o.nxm !== e.nxm) begin
          miscompares++;
          $display("FAIL rnd_nxm t=%0d: got %b required %b", t, o.nxm, e.nxm);
        end
      end else if (!we) begin
        vectors++;
        if (o.rdata !== e.rdata) begin
          miscompares++;
          $display("FAIL rnd_rdata t=%0d: got %h required %h", t, o.rdata, e.rdata);
        end
      end
      vectors++;
      if (o.mreq_cyc != e.mreq_cyc || o.unstable || o.extra) begin
        miscompares++;
        $display("FAIL rnd_mreq t=%0d: got cycles=%0d unst=%0d extra=%0d required cycles=%0d",
                 t, o.mreq_cyc, o.unstable, o.extra, e.mreq_cyc);
      end
      if (e.mreq_cyc > 0) begin
        vectors++;
        if ({o.we, o.be, o.addr, o.wdata} !== {e.we, e.be, e.addr, e.wdata}) begin
          miscompares++;
          $display("FAIL rnd_bus t=%0d: got we=%b be=%b addr=%h wd=%h required we=%b be=%b addr=%h wd=%h",
                   t, o.we, o.be, o.addr, o.wdata, e.we, e.be, e.addr, e.wdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid_busy;
    bit pulse_seen = 0;
    mem_lat = 0;
    req_we[1] = 1'b0; req_byte[1] = 1'b0; req_addr[31:16] = 16'o002000;
    req_valid[1] = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_busy_pre: got mem_req=%b required 1", mem_req);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, rsp_done, rsp_err, rsp_trap_nxm, rsp_rdata} !== 58'h0) begin
      miscompares++;
      $display("FAIL rst_busy_drop: got req=%b be=%b addr=%h done=%b err=%b required all zero",
               mem_req, mem_be, mem_addr, rsp_done, rsp_err);
    end
    @(negedge clk);
    if ((rsp_done | rsp_err) != 3'b000) pulse_seen = 1;
    mem_lat = 1;
    rst_n = 1'b1;
    @(negedge clk);
    if ((rsp_done | rsp_err) != 3'b000) pulse_seen = 1;
    vectors++;
    if (mem_req !== 1'b1 || pulse_seen) begin
      miscompares++;
      $display("FAIL rst_busy_restart: got mem_req=%b pulse=%0d required 1 0", mem_req, pulse_seen);
    end
    @(negedge clk);
    vectors++;
    if (rsp_done !== 3'b010 || rsp_err !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_busy_done: got done=%b err=%b required 010 000", rsp_done, rsp_err);
    end
    req_valid[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention;
    int order[4];
    int n = 0, last_c = 0, gap_bad = 0, ptr, exp_idx;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_lat = 1;
    req_we = 3'b000; req_byte = 3'b000;
    req_addr = {16'h0030, 16'h0020, 16'h0010};
    req_valid = 3'b111;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(negedge clk);
      if ((rsp_done | rsp_err) != 3'b000) begin
        order[n] = -1;
        for (int j = 0; j < NUM_REQ; j++) if (rsp_done[j]) order[n] = j;
        if (n > 0 && c - last_c != 3) gap_bad++;
        last_c = c;
        n++;
      end
    end
    req_valid = 3'b000;
    @(negedge clk);
    vectors++;
    if (n != 4 || gap_bad != 0) begin
      miscompares++;
      $display("FAIL contention_grants: got %0d grants, %0d bad gaps required 4 grants 3 cycles apart", n, gap_bad);
    end
    ptr = NUM_REQ - 1;
    for (int k = 0; k < n; k++) begin
`ifdef PDP11_ARB_RR_EN
      exp_idx = (ptr + 1) % NUM_REQ;
      ptr = exp_idx;
`else
      exp_idx = 0;
`endif
      vectors++;
      if (order[k] != exp_idx) begin
        miscompares++;
        $display("FAIL contention_order[%0d]: got %0d required %0d", k, order[k], exp_idx);
      end
    end
  endtask

  initial begin
    req_valid = 3'b000;
    req_we = 3'($urandom); req_byte = 3'($urandom);
    req_addr = {$urandom, 16'($urandom)}; req_wdata = {$urandom, 16'($urandom)};
    mem_ready = 1'b0;
    mem_rdata = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 16'($urandom);
      ref_mem[i] = mem_arr[i];
    end
    test_reset();
    test_word_read();
    test_byte_write();
    test_odd_trap();
    test_nxm_timeout();
    test_random();
    test_reset_mid_busy();
    test_contention();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
